// File: rtl/dcache_mem_pkg.sv
// -----------------------------------------------------------------------------
// dcache_mem_pkg
//   Shared types and helpers for the data-cache memory responder:
//   FSM state encoding, access-size encoding, line length and the byte-lane
//   mask implied by an access size and the low address bits.
// -----------------------------------------------------------------------------
package dcache_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WAIT   = 2'd2,
    DATA   = 2'd3
  } state_t;

  // Encoding 3 is not named; it behaves as a full word.
  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_t;

  // Words per cache line for a given line-offset width.
  function automatic int line_words(input int offset_width);
    return 2 << offset_width;
  endfunction

  // Byte lanes an access of the given size touches at address bits [1:0].
  function automatic logic [3:0] size_mask(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
    logic [3:0] m;
    case (size)
      SIZE_B:  m = 4'b0001 << addr_lo;
      SIZE_H:  m = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dcache_mem_lfsr.sv
// -----------------------------------------------------------------------------
// dcache_mem_lfsr
//   8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seeded with 8'hA5 at reset and
//   advancing every cycle. Its low bit is offered as an acceptance enable so
//   the responder can apply deterministic pseudo-random backpressure.
//
// Ports
//   clk        in   clock
//   rstn       in   asynchronous active-low reset
//   accept_en  out  1 when the responder may accept a request this cycle
// -----------------------------------------------------------------------------
module dcache_mem_lfsr (
  input  logic clk,
  input  logic rstn,
  output logic accept_en
);

  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign accept_en = lfsr_q[0];

endmodule

// File: rtl/dcache_mem_responder.sv
// -----------------------------------------------------------------------------
// dcache_mem_responder
//   Memory-side responder for the Dcache / uncached-DMA memory port. Accepts
//   one request at a time over the req/addrOK/dataOK handshake, applies
//   byte-masked word writes to a word-addressed backing RAM, and returns a
//   whole line for reads after a fixed latency. Reads start at the requested
//   word (no line alignment) and wrap at the end of the RAM.
//
//   Optional feature: define DCACHE_MEM_RAND_STALL_EN to gate acceptance in
//   IDLE with an LFSR, giving deterministic pseudo-random backpressure.
//
// Parameters
//   offset_width    line offset bits; line = 2<<offset_width words
//   mem_addr_width  RAM depth = 2**mem_addr_width 32-bit words
//   read_lat        cycles spent in WAIT before dataOK (1..15)
//
// Ports
//   clk                in   clock
//   rstn               in   asynchronous active-low reset
//   addr_dcache_mem    in   byte address of request
//   dout_dcache_mem    in   write data, byte lanes aligned to address
//   dcache_mem_req     in   request valid, held until addrOK
//   dcache_mem_wr      in   0 read, 1 write
//   dcache_mem_size    in   0 byte, 1 half, 2/3 word
//   dcache_mem_wstrb   in   byte write enables
//   mem_dcache_addrOK  out  request accepted (one-cycle pulse)
//   mem_dcache_dataOK  out  read line valid (one-cycle pulse)
//   din_mem_dcache     out  read line, word i at bits [32i+31:32i]
// -----------------------------------------------------------------------------
module dcache_mem_responder
  import dcache_mem_pkg::*;
#(
  parameter int offset_width   = 2,
  parameter int mem_addr_width = 10,
  parameter int read_lat       = 3
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [31:0]                          addr_dcache_mem,
  input  logic [31:0]                          dout_dcache_mem,
  input  logic                                 dcache_mem_req,
  input  logic                                 dcache_mem_wr,
  input  logic [1:0]                           dcache_mem_size,
  input  logic [3:0]                           dcache_mem_wstrb,
  output logic                                 mem_dcache_addrOK,
  output logic                                 mem_dcache_dataOK,
  output logic [32*(2<<offset_width)-1:0]      din_mem_dcache
);

  localparam int n_words = line_words(offset_width);
  localparam int depth   = 1 << mem_addr_width;

  state_t                      state;
  logic [mem_addr_width-1:0]   req_idx;
  logic [1:0]                  req_lane;
  logic [31:0]                 req_data;
  logic                        req_wr;
  logic [1:0]                  req_size;
  logic [3:0]                  req_wstrb;
  logic [3:0]                  lat_cnt;
  logic                        addr_ok;
  logic                        data_ok;
  logic [32*n_words-1:0]       line_q;
  logic [3:0]                  wr_mask;
  logic                        accept_en;

  logic [31:0] ram [depth];

  // Address bits above the RAM index alias and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_dcache_mem[31:mem_addr_width+2];

`ifdef DCACHE_MEM_RAND_STALL_EN
  dcache_mem_lfsr u_lfsr (
    .clk       (clk),
    .rstn      (rstn),
    .accept_en (accept_en)
  );
`else
  assign accept_en = 1'b1;
`endif

  assign wr_mask = size_mask(req_size, req_lane) & req_wstrb;

  // Control FSM. addrOK/dataOK are registered alongside the state so that
  // neither has a combinational path from the request inputs.
  // NOTE: all state here is updated with non-blocking assignments so every
  // flop samples the pre-edge values of the others, as real hardware does.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      req_idx   <= '0;
      req_lane  <= '0;
      req_data  <= '0;
      req_wr    <= 1'b0;
      req_size  <= '0;
      req_wstrb <= '0;
      lat_cnt   <= '0;
      addr_ok   <= 1'b0;
      data_ok   <= 1'b0;
      line_q    <= '0;
    end else begin
      addr_ok <= 1'b0;
      data_ok <= 1'b0;
      case (state)
        IDLE: begin
          if (dcache_mem_req && accept_en) begin
            req_idx   <= addr_dcache_mem[mem_addr_width+1:2];
            req_lane  <= addr_dcache_mem[1:0];
            req_data  <= dout_dcache_mem;
            req_wr    <= dcache_mem_wr;
            req_size  <= dcache_mem_size;
            req_wstrb <= dcache_mem_wstrb;
            addr_ok   <= 1'b1;
            state     <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (req_wr) begin
            state <= IDLE;
          end else begin
            lat_cnt <= 4'(read_lat - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 4'd0) begin
            // Index arithmetic is mem_addr_width bits wide, so a line that
            // runs off the top of the RAM wraps to word 0.
            for (int i = 0; i < n_words; i++) begin
              line_q[32*i +: 32] <= ram[req_idx + mem_addr_width'(i)];
            end
            data_ok <= 1'b1;
            state   <= DATA;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        DATA: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Backing store. The write commits on the clock edge that ends ACCEPT.
  // NOTE: the RAM has no reset on purpose; contents survive rstn so that a
  // write committed before a reset is still visible afterwards.
  always_ff @(posedge clk) begin
    if (state == ACCEPT && req_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) begin
          ram[req_idx][8*b +: 8] <= req_data[8*b +: 8];
        end
      end
    end
  end

  assign mem_dcache_addrOK = addr_ok;
  assign mem_dcache_dataOK = data_ok;
  assign din_mem_dcache    = line_q;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_dcache_mem_responder
//   Self-checking bench for dcache_mem_responder (default parameters). A
//   behavioural RAM model predicts each read line; the expected line and the
//   cycle it is due are queued at addrOK and compared when dataOK arrives.
//   Build with DCACHE_MEM_RAND_STALL_EN to also check LFSR backpressure.
// -----------------------------------------------------------------------------
module tb_dcache_mem_responder;

  localparam int RL    = 3;
  localparam int NW    = 8;
  localparam int DEPTH = 1024;

  logic            clk = 1'b0;
  logic            rstn;
  logic [31:0]     addr_i;
  logic [31:0]     dout_i;
  logic            req;
  logic            wr_i;
  logic [1:0]      size_i;
  logic [3:0]      wstrb_i;
  logic            addr_ok;
  logic            data_ok;
  logic [32*NW-1:0] din;

  always #5 clk = ~clk;

  dcache_mem_responder #(
    .offset_width   (2),
    .mem_addr_width (10),
    .read_lat       (RL)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .addr_dcache_mem   (addr_i),
    .dout_dcache_mem   (dout_i),
    .dcache_mem_req    (req),
    .dcache_mem_wr     (wr_i),
    .dcache_mem_size   (size_i),
    .dcache_mem_wstrb  (wstrb_i),
    .mem_dcache_addrOK (addr_ok),
    .mem_dcache_dataOK (data_ok),
    .din_mem_dcache    (din)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- model ---
  typedef struct {
    logic [255:0] line;
    int           due;
  } exp_t;

  logic [31:0] mem_model [DEPTH];
  exp_t        sb_q [$];
  int          cyc = 0;
  int          n_issued = 0;
  int          n_reads = 0;
  int          n_addrok = 0;
  int          n_dataok = 0;
  int          last_addrok = 0;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef DCACHE_MEM_RAND_STALL_EN
  // lfsr_prev holds the value the DUT's LFSR had at the most recent edge.
  logic [7:0] lfsr_m, lfsr_prev;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_m    <= 8'hA5;
      lfsr_prev <= 8'hA5;
    end else begin
      lfsr_m    <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
      lfsr_prev <= lfsr_m;
    end
  end
`endif

  // -------------------------------------------------------------- monitor ---
  logic         hold_chk = 1'b0;
  logic [255:0] held     = '0;
  logic         prev_aok = 1'b0;
  logic         prev_dok = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      hold_chk <= 1'b0;
      prev_aok <= 1'b0;
      prev_dok <= 1'b0;
    end else begin
      if (hold_chk) check("din_hold_after_dataOK", din, held);
      if (prev_aok) check("addrOK_single_pulse", addr_ok, 1'b0);
      if (prev_dok) check("dataOK_single_pulse", data_ok, 1'b0);
      hold_chk <= 1'b0;
      prev_aok <= addr_ok;
      prev_dok <= data_ok;
      if (addr_ok) n_addrok <= n_addrok + 1;
      if (data_ok) begin
        n_dataok <= n_dataok + 1;
        if (sb_q.size() == 0) begin
          check("spurious_dataOK", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check("read_line", din, e.line);
          check("read_latency_cycle", 256'(cyc), 256'(e.due));
          held     <= e.line;
          hold_chk <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------- driver ---
  // Called at a negedge with the DUT idle. Returns at a negedge with the DUT
  // idle again, so a following call re-asserts req in the cycle after the
  // write's ACCEPT (or after the read's DATA).
  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] size,
                       input logic [3:0] wstrb);
    int           n;
    logic         got;
    logic [9:0]   idx;
    logic [3:0]   m;
    logic [255:0] line;
    addr_i  = addr;
    dout_i  = data;
    wr_i    = wr;
    size_i  = size;
    wstrb_i = wstrb;
    req     = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
`ifdef DCACHE_MEM_RAND_STALL_EN
      if (addr_ok) check("stall_accept_on_lfsr1", lfsr_prev[0], 1'b1);
      else         check("stall_hold_on_lfsr0", lfsr_prev[0], 1'b0);
`endif
      got = addr_ok;
    end
    req = 1'b0;
    if (!got) begin
      check("addrOK_timeout", 1'b0, 1'b1);
      return;
    end
`ifndef DCACHE_MEM_RAND_STALL_EN
    check("addrOK_latency", 256'(n), 256'd1);
`endif
    last_addrok = cyc;
    n_issued++;
    idx = addr[11:2];
    if (wr) begin
      case (size)
        2'd0:    m = 4'b0001 << addr[1:0];
        2'd1:    m = addr[1] ? 4'b1100 : 4'b0011;
        default: m = 4'b1111;
      endcase
      m = m & wstrb;
      for (int b = 0; b < 4; b++)
        if (m[b]) mem_model[idx][8*b +: 8] = data[8*b +: 8];
      @(negedge clk);
    end else begin
      for (int i = 0; i < NW; i++) line[32*i +: 32] = mem_model[(int'(idx) + i) % DEPTH];
      sb_q.push_back('{line: line, due: cyc + RL + 1});
      n_reads++;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!data_ok && n < 100);
      if (!data_ok) check("dataOK_timeout", 1'b0, 1'b1);
      @(negedge clk);
    end
  endtask

  // ------------------------------------------------------------- stimulus ---
  initial begin
    int t1;
    int n;
    logic got;
    rstn = 1'b0; req = 1'b0; addr_i = '0; dout_i = '0;
    wr_i = 1'b0; size_i = '0; wstrb_i = '0;
    repeat (2) @(negedge clk);
    check("reset_addrOK", addr_ok, 1'b0);
    check("reset_dataOK", data_ok, 1'b0);
    check("reset_din", din, '0);
    rstn = 1'b1;
    @(negedge clk);

    // Known RAM contents everywhere.
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), $urandom, 2'd2, 4'hF);

    // Word write then read; words 1..7 come from RAM[0x11..0x17].
    issue(1'b1, 32'h40, 32'hDEADBEEF, 2'd2, 4'hF);
    issue(1'b0, 32'h40, 32'h0, 2'd2, 4'h0);
    check("word_write_w0", din[31:0], 32'hDEADBEEF);

    // Byte and halfword writes.
    issue(1'b1, 32'h80, 32'h11223344, 2'd2, 4'hF);
    issue(1'b1, 32'h82, 32'h00AA0000, 2'd0, 4'b0100);
    issue(1'b0, 32'h80, 32'h0, 2'd2, 4'h0);
    check("byte_write", din[31:0], 32'h11AA3344);
    issue(1'b1, 32'h80, 32'h55556666, 2'd1, 4'hF);
    issue(1'b0, 32'h80, 32'h0, 2'd2, 4'h0);
    check("half_write", din[31:0], 32'h11AA6666);

    // Zero mask writes nothing; size 3 acts as a word.
    issue(1'b1, 32'h80, 32'hFFFFFFFF, 2'd2, 4'h0);
    issue(1'b1, 32'h84, 32'hCAFEF00D, 2'd3, 4'hF);
    issue(1'b0, 32'h80, 32'h0, 2'd2, 4'h0);
    check("zero_mask_write", din[31:0], 32'h11AA6666);
    check("size3_write", din[63:32], 32'hCAFEF00D);

    // Wrap at the end of RAM, and high address bits aliasing.
    issue(1'b0, 32'hFF8, 32'h0, 2'd2, 4'h0);
    issue(1'b1, 32'h0000_1040, 32'h0BADCAFE, 2'd2, 4'hF);
    issue(1'b0, 32'h40, 32'h0, 2'd2, 4'h0);
    check("alias_write", din[31:0], 32'h0BADCAFE);

    // Back-to-back write then read of the same word.
    issue(1'b1, 32'h200, 32'h13579BDF, 2'd2, 4'hF);
    t1 = last_addrok;
    issue(1'b0, 32'h200, 32'h0, 2'd2, 4'h0);
`ifndef DCACHE_MEM_RAND_STALL_EN
    check("b2b_addrOK_gap", 256'(last_addrok - t1), 256'd2);
`endif
    check("b2b_read_new", din[31:0], 32'h13579BDF);

    // Reset while the read sits in WAIT: aborted, no dataOK.
    issue(1'b1, 32'h300, 32'hA5A5F00F, 2'd2, 4'hF);
    addr_i = 32'h300; wr_i = 1'b0; req = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      got = addr_ok;
    end
    req = 1'b0;
    if (!got) check("rst_addrOK_timeout", 1'b0, 1'b1);
    else n_issued++;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_wait_addrOK", addr_ok, 1'b0);
    check("rst_wait_dataOK", data_ok, 1'b0);
    check("rst_wait_din", din, '0);
    for (int i = 0; i < RL + 2; i++) begin
      @(negedge clk);
      check("rst_no_dataOK", data_ok, 1'b0);
    end
    rstn = 1'b1;
    @(negedge clk);
    issue(1'b0, 32'h300, 32'h0, 2'd2, 4'h0);
    check("write_persists_reset", din[31:0], 32'hA5A5F00F);

    // Random mixed traffic.
    for (int k = 0; k < 100; k++) begin
      issue(1'($urandom_range(0, 1)), $urandom, $urandom,
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 256'(sb_q.size()), 256'd0);
    check("addrOK_count", 256'(n_addrok), 256'(n_issued));
    check("dataOK_count", 256'(n_dataok), 256'(n_reads));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache_mem_responder.md
Name: dcache_mem_responder

Overview:
- Memory-side responder for the data-cache/uncached-DMA memory port.
- Accepts the req/addrOK/dataOK handshake, holds a word-addressed backing RAM, and returns a full line (2<<offset_width words) for reads.
- Applies byte-masked word writes.
- Sits below the Dcache/DMA in system-level and unit benches, and doubles as the simulation memory for the L1 data path.

Parameters:
- offset_width, 2, line offset bits; line = 2<<offset_width words (default 8 words, 256 bits).
- mem_addr_width, 10, backing RAM depth = 2^mem_addr_width 32-bit words.
- read_lat, 3, cycles in WAIT before dataOK (legal range 1..15).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- addr_dcache_mem  in  32  byte address of request
- dout_dcache_mem  in  32  write data, byte lanes aligned to address
- dcache_mem_req  in  1  request valid; held by initiator until addrOK
- dcache_mem_wr  in  1  0-read 1-write
- dcache_mem_size  in  2  0-1byte 1-2byte 2-4byte (3 treated as 2)
- dcache_mem_wstrb  in  4  byte write enables
- mem_dcache_addrOK  out  1  request accepted, one-cycle pulse
- mem_dcache_dataOK  out  1  read data valid, one-cycle pulse
- din_mem_dcache  out  32*(2<<offset_width)  read line; word i at bits [32i+31:32i]

Behaviour:
- Reset: the clock is clk; reset is asynchronous and active-low on rstn.
  - On reset: state=IDLE, addrOK=0, dataOK=0, din_mem_dcache=0.
  - RAM contents are not cleared.
- All outputs are registered or decoded from state only. No combinational path from req to addrOK.
- One outstanding request at a time.
- IDLE:
  - If req=1, latch addr/data/wr/size/wstrb and go to ACCEPT.
  - Otherwise stay in IDLE.
- ACCEPT:
  - addrOK=1 for exactly this cycle. req is ignored.
  - Write: commit the masked write to RAM on this clock edge, then go to IDLE.
  - Read: load the latency counter with read_lat-1, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture the line into din_mem_dcache and go to DATA.
- DATA:
  - dataOK=1 for exactly this cycle, then go to IDLE.
- din_mem_dcache holds its value until the next read capture, so the initiator may sample it in the cycle after dataOK.
- Latency, with req rising in cycle 0:
  - addrOK in cycle 1.
  - Read: dataOK in cycle 2+read_lat.
  - A new req seen in cycle 2 (write) or cycle 3+read_lat (read) is accepted.
- RAM indexing:
  - idx = addr[mem_addr_width+1:2]. Higher address bits are ignored, so addresses alias.
  - Read word i = RAM[(idx+i) mod 2^mem_addr_width]. The address is not forced to line alignment; the wrap is at the end of RAM.
- Write mask = wstrb AND size_mask:
  - size0: one-hot lane addr[1:0].
  - size1: lanes {addr[1],0} and {addr[1],1}.
  - size2: 4'b1111.
  - Lane b takes dout[8b+7:8b]. A mask of 0 is accepted but writes nothing.
- Reset mid-operation aborts the operation with no dataOK. A write committed in ACCEPT before reset persists.
- req dropping while in ACCEPT/WAIT/DATA has no effect: the latched request completes.

Optional Feature:
- Macro: DCACHE_MEM_RAND_STALL_EN.
- Enabled:
  - An 8-bit LFSR (seed 8'hA5 at reset, taps x^8+x^6+x^5+x^4+1, shifting every cycle) gates acceptance.
  - In IDLE with req=1, transition to ACCEPT only when lfsr[0]=1; otherwise stay in IDLE (backpressure).
  - Deterministic, for exercising the initiator's req-hold path.
- Disabled: IDLE accepts on the first cycle req=1. No LFSR logic is present.

Decomposition:
- Package dcache_mem_pkg:
  - state encoding IDLE/ACCEPT/WAIT/DATA;
  - size encodings SIZE_B/SIZE_H/SIZE_W;
  - function line_words(offset_width);
  - function size_mask(size, addr[1:0]).
- One sub-module: dcache_mem_lfsr (8-bit LFSR with enable output), instantiated only under DCACHE_MEM_RAND_STALL_EN.

Test Plan:
- Word write then read: write addr 0x40, wstrb 4'hF, data 0xDEADBEEF; read 0x40.
  - Required: addrOK in cycle 1 of each request.
  - Required: dataOK 2+read_lat cycles after the read req.
  - Required: word0=0xDEADBEEF and words 1..7 = RAM[0x11..0x17].
- Byte write: preload 0x11223344 at 0x80; write size0, addr 0x82, wstrb 4'b0100, data 0x00AA0000.
  - Required: read returns 0x11AA3344.
  - Also: size1, addr 0x80, wstrb 4'hF, data 0x5555_6666 -> 0x11AA6666.
- Wrap-around: with mem_addr_width=10, read addr 0xFF8 (idx 1022).
  - Required: words 0..7 = RAM[1022], RAM[1023], RAM[0..5].
- Back-to-back traffic: write immediately followed by read (req re-asserted in the cycle after addrOK).
  - Required: the second addrOK occurs exactly 2 cycles after the first.
  - Required: the read returns the new data.
  - Required: din_mem_dcache stays stable for the cycle after dataOK.
- Reset in WAIT: assert rstn=0 during a read.
  - Required: no dataOK; addrOK/dataOK/din all 0.
  - Required: an earlier write persists after reset.
- With DCACHE_MEM_RAND_STALL_EN: hold req=1.
  - Required: addrOK appears only on a cycle after lfsr[0]=1 was sampled in IDLE.
  - Required: req is never dropped before addrOK, and no request is lost or duplicated across 100 random transactions.
